// File: rtl/sram_march_bist.sv
// March C- built-in self test for a single-port SRAM: one op per RUN cycle, first-mismatch capture.
// Define SRAM_BIST_CHECKERBOARD_EN to append a second pass on a 0x55.. / 0xAA.. background.
module sram_march_bist #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_W-1:0]     fail_addr_o,
`ifdef SRAM_BIST_CHECKERBOARD_EN
  output logic [3:0]            fail_elem_o,
`else
  output logic [2:0]            fail_elem_o,
`endif
  output logic                  sram_cs_o,
  output logic [ADDR_W-1:0]     sram_addr_o,
  output logic [DATA_W-1:0]     sram_data_o,
  output logic [DATA_W/8-1:0]   sram_mask_o,
  output logic                  sram_wren_o,
  input  logic [DATA_W-1:0]     sram_data_i
);

`ifdef SRAM_BIST_CHECKERBOARD_EN
  localparam int unsigned ElemW = 4;
  localparam logic [DATA_W-1:0] CheckerBg = {(DATA_W/2){2'b01}};
`else
  localparam int unsigned ElemW = 3;
`endif
  localparam logic [ADDR_W-1:0] MaxAddr = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          elem_q, elem_d;
  logic                op_q, op_d;          // second (write) op of a two-op element
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [ElemW-1:0]    pend_elem_q, pend_elem_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [ElemW-1:0]    fail_elem_q, fail_elem_d;

  logic [DATA_W-1:0]   bg0;
  logic [ElemW-1:0]    cur_elem;
  logic                two_op, down, is_read, data_one, last_addr;
  logic [DATA_W-1:0]   data_pat;

`ifdef SRAM_BIST_CHECKERBOARD_EN
  logic pass_q, pass_d;
  assign bg0      = pass_q ? CheckerBg : '0;
  assign cur_elem = {pass_q, elem_q};
`else
  assign bg0      = '0;
  assign cur_elem = elem_q;
`endif

  // Elements 1-4 are read-then-write; elements 3-5 walk downwards.
  assign two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
  assign down      = (elem_q >= 3'd3);
  assign is_read   = (elem_q != 3'd0) && !op_q;
  assign data_one  = is_read ? ((elem_q == 3'd2) || (elem_q == 3'd4))
                             : ((elem_q == 3'd1) || (elem_q == 3'd3));
  assign data_pat  = data_one ? ~bg0 : bg0;
  assign last_addr = down ? (addr_q == '0) : (addr_q == MaxAddr);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    elem_d      = elem_q;
    op_d        = op_q;
    pend_d      = 1'b0;
    exp_d       = exp_q;
    pend_addr_d = pend_addr_q;
    pend_elem_d = pend_elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
`ifdef SRAM_BIST_CHECKERBOARD_EN
    pass_d      = pass_q;
`endif
    busy_o      = 1'b0;
    done_o      = 1'b0;
    sram_cs_o   = 1'b0;
    sram_addr_o = '0;
    sram_data_o = '0;
    sram_mask_o = '0;
    sram_wren_o = 1'b0;

    // Read data returns one cycle after the read; only the first miscompare is kept.
    if (pend_q && (sram_data_i != exp_q) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = pend_addr_q;
      fail_elem_d = pend_elem_q;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          addr_d      = '0;
          elem_d      = '0;
          op_d        = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
`ifdef SRAM_BIST_CHECKERBOARD_EN
          pass_d      = 1'b0;
`endif
        end
      end
      StRun: begin
        busy_o      = 1'b1;
        sram_cs_o   = 1'b1;
        sram_mask_o = '1;
        sram_addr_o = addr_q;
        sram_data_o = data_pat;
        sram_wren_o = !is_read;
        if (is_read) begin
          pend_d      = 1'b1;
          exp_d       = data_pat;
          pend_addr_d = addr_q;
          pend_elem_d = cur_elem;
        end
        if (two_op && !op_q) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_addr) begin
            addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem_q != 3'd5) begin
            elem_d = elem_q + 3'd1;
            addr_d = (elem_q >= 3'd2) ? MaxAddr : '0;
          end else begin
`ifdef SRAM_BIST_CHECKERBOARD_EN
            if (!pass_q) begin
              pass_d = 1'b1;
              elem_d = '0;
              addr_d = '0;
            end else begin
              state_d = StDrain;
            end
`else
            state_d = StDrain;
`endif
          end
        end
      end
      StDrain: begin
        busy_o  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      elem_q      <= '0;
      op_q        <= 1'b0;
      pend_q      <= 1'b0;
      exp_q       <= '0;
      pend_addr_q <= '0;
      pend_elem_q <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
`ifdef SRAM_BIST_CHECKERBOARD_EN
      pass_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      pend_q      <= pend_d;
      exp_q       <= exp_d;
      pend_addr_q <= pend_addr_d;
      pend_elem_q <= pend_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
`ifdef SRAM_BIST_CHECKERBOARD_EN
      pass_q      <= pass_d;
`endif
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: faulty SRAM model, expected op trace and first-fail reference model.
module tb_sram_march_bist;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int N  = 1 << AW;
`ifdef SRAM_BIST_CHECKERBOARD_EN
  localparam int NPASS = 2;
  localparam int EW    = 4;
`else
  localparam int NPASS = 1;
  localparam int EW    = 3;
`endif
  localparam int NOPS = 10 * N * NPASS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [EW-1:0] fail_elem;
  logic          sram_cs, sram_wren;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW/8-1:0] sram_mask;
  logic [DW-1:0] rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .sram_cs_o   (sram_cs),
    .sram_addr_o (sram_addr),
    .sram_data_o (sram_wdata),
    .sram_mask_o (sram_mask),
    .sram_wren_o (sram_wren),
    .sram_data_i (rdata)
  );

  // Fault config: kind 0 none, 1 stuck-at (bit f_bit reads f_val at f_addr),
  // 2 coupling (a write raising bit f_bit of f_addr forces that bit of f_vic high).
  int          f_kind = 0;
  logic [AW-1:0] f_addr = '0;
  logic [AW-1:0] f_vic = '0;
  int          f_bit = 0;
  logic        f_val = 1'b0;

  function automatic logic [DW-1:0] rd_fault(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  function automatic bit cpl_hit(input logic [AW-1:0] a, input logic [DW-1:0] o,
                                 input logic [DW-1:0] n);
    return (f_kind == 2) && (a == f_addr) && !o[f_bit] && n[f_bit];
  endfunction

  function automatic logic [DW-1:0] bitmask(input int b);
    logic [DW-1:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                          input logic [DW/8-1:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < DW / 8; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  logic [DW-1:0] mem [N];
  logic          mem_clr = 1'b0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else if (sram_cs) begin
      if (sram_wren) begin
        mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_mask);
        if (cpl_hit(sram_addr, mem[sram_addr], merge(mem[sram_addr], sram_wdata, sram_mask)))
          mem[f_vic] <= mem[f_vic] | bitmask(f_bit);
      end else begin
        rdata <= rd_fault(sram_addr, mem[sram_addr]);
      end
    end
  end

  // Expected op stream of the whole test, straight from the March C- element list.
  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] data;
    int            elem;
  } op_t;
  op_t exp_ops[$];

  task automatic push_op(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                         input int el);
    op_t o;
    o.addr = a; o.wr = w; o.data = d; o.elem = el;
    exp_ops.push_back(o);
  endtask

  task automatic build_ops();
    logic [AW-1:0] a;
    logic [DW-1:0] b0, b1;
    exp_ops.delete();
    for (int p = 0; p < NPASS; p++) begin
      b0 = (p == 1) ? 32'h5555_5555 : 32'h0;
      b1 = ~b0;
      for (int e = 0; e < 6; e++) begin
        for (int i = 0; i < N; i++) begin
          a = (e >= 3) ? AW'(N - 1 - i) : AW'(i);
          case (e)
            0: push_op(a, 1'b1, b0, p * 8 + e);
            1: begin push_op(a, 1'b0, b0, p * 8 + e); push_op(a, 1'b1, b1, p * 8 + e); end
            2: begin push_op(a, 1'b0, b1, p * 8 + e); push_op(a, 1'b1, b0, p * 8 + e); end
            3: begin push_op(a, 1'b0, b0, p * 8 + e); push_op(a, 1'b1, b1, p * 8 + e); end
            4: begin push_op(a, 1'b0, b1, p * 8 + e); push_op(a, 1'b1, b0, p * 8 + e); end
            default: push_op(a, 1'b0, b0, p * 8 + e);
          endcase
        end
      end
    end
  endtask

  // Replays the op stream on an ideal array with the configured fault; first bad read wins.
  logic [DW-1:0] ref_mem [N];
  task automatic model_run(output bit mf, output logic [AW-1:0] ma, output int me);
    logic [DW-1:0] o, g;
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    mf = 0; ma = '0; me = 0;
    foreach (exp_ops[k]) begin
      if (exp_ops[k].wr) begin
        o = ref_mem[exp_ops[k].addr];
        ref_mem[exp_ops[k].addr] = exp_ops[k].data;
        if (cpl_hit(exp_ops[k].addr, o, exp_ops[k].data))
          ref_mem[f_vic] = ref_mem[f_vic] | bitmask(f_bit);
      end else begin
        g = rd_fault(exp_ops[k].addr, ref_mem[exp_ops[k].addr]);
        if (g != exp_ops[k].data && !mf) begin
          mf = 1; ma = exp_ops[k].addr; me = exp_ops[k].elem;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk) mem_clr = 1'b1;
    @(negedge clk) mem_clr = 1'b0;
  endtask

  // Cycle 1 is the cycle after the edge that samples start.
  task automatic run_test(input string tag, input bit extra, input bit e_fail,
                          input logic [AW-1:0] e_addr, input int e_elem);
    int busy_bad = 0, done_cnt = 0, done_at = -1, trace_bad = 0, first_bad = -1;
    op_t o;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= NOPS + 6; c++) begin
      @(negedge clk);
      start = extra && (c == 5 || c == 5000);
      if (busy !== (c <= NOPS + 1)) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c <= NOPS) begin
        o = exp_ops[c-1];
        if (sram_cs !== 1'b1 || sram_wren !== o.wr || sram_addr !== o.addr ||
            sram_mask !== '1 || (o.wr && sram_wdata !== o.data)) begin
          if (trace_bad == 0) first_bad = c;
          trace_bad++;
        end
      end else if (sram_cs !== 1'b0) begin
        if (trace_bad == 0) first_bad = c;
        trace_bad++;
      end
    end
    chk({tag, "_busy_window_bad_cycles"}, 64'(busy_bad), 64'd0);
    chk({tag, "_done_cycle"}, 64'(done_at), 64'(NOPS + 2));
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    chk($sformatf("%s_op_trace_bad(first_cycle=%0d)", tag, first_bad), 64'(trace_bad), 64'd0);
    chk({tag, "_fail"}, 64'(fail), 64'(e_fail));
    chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(e_addr));
    chk({tag, "_fail_elem"}, 64'(fail_elem), 64'(e_elem));
  endtask

  typedef struct {
    string         name;
    int            kind;
    logic [AW-1:0] addr;
    logic [AW-1:0] vic;
    int            bitn;
    logic          val;
    bit            extra;
    bit            use_model;
    bit            e_fail;
    logic [AW-1:0] e_addr;
    int            e_elem;
  } vec_t;
  vec_t vecs[6];

  initial begin
    bit            mf;
    logic [AW-1:0] ma;
    int            me;

    vecs[0] = '{"clean_extra_starts", 0, 10'h000, 10'h000, 0, 1'b0, 1, 0, 0, 10'h000, 0};
    vecs[1] = '{"stuck1_155", 1, 10'h155, 10'h000, 0, 1'b1, 0, 0, 1, 10'h155, 1};
    vecs[2] = '{"couple_3ff_3fe", 2, 10'h3FF, 10'h3FE, 7, 1'b0, 0, 0, 1, 10'h3FE, 3};
    vecs[3] = '{"stuck0_000", 1, 10'h000, 10'h000, 0, 1'b0, 0, 0, 1, 10'h000, 2};
    for (int r = 4; r < 6; r++) begin
      vecs[r].name      = $sformatf("random%0d", r);
      vecs[r].kind      = int'($urandom_range(1, 2));
      vecs[r].addr      = AW'($urandom_range(0, N - 1));
      vecs[r].vic       = vecs[r].addr ^ AW'($urandom_range(1, N - 1));
      vecs[r].bitn      = int'($urandom_range(0, DW - 1));
      vecs[r].val       = 1'($urandom_range(0, 1));
      vecs[r].extra     = 0;
      vecs[r].use_model = 1;
    end
    build_ops();

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_fail", 64'(fail), 64'd0);
    chk("reset_cs", 64'(sram_cs), 64'd0);
    chk("reset_mask", 64'(sram_mask), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      f_kind = vecs[v].kind; f_addr = vecs[v].addr; f_vic = vecs[v].vic;
      f_bit = vecs[v].bitn; f_val = vecs[v].val;
      if (vecs[v].use_model) begin
        model_run(mf, ma, me);
        vecs[v].e_fail = mf; vecs[v].e_addr = ma; vecs[v].e_elem = me;
      end
      clear_mem();
      run_test(vecs[v].name, vecs[v].extra, vecs[v].e_fail, vecs[v].e_addr, vecs[v].e_elem);
    end

    // Mid-run reset while the read of 0x3DB (cycle 2999) is awaiting its compare.
    f_kind = 1; f_addr = 10'h3DB; f_bit = 0; f_val = 1'b1;
    clear_mem();
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midrst_pre_fail", 64'(fail), 64'd0);
    chk("midrst_pre_addr", 64'(sram_addr), 64'h3DB);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_fail", 64'(fail), 64'd0);
    chk("midrst_fail_addr", 64'(fail_addr), 64'd0);
    chk("midrst_fail_elem", 64'(fail_elem), 64'd0);
    chk("midrst_cs", 64'(sram_cs), 64'd0);
    chk("midrst_wren", 64'(sram_wren), 64'd0);
    chk("midrst_addr", 64'(sram_addr), 64'd0);
    chk("midrst_data", 64'(sram_wdata), 64'd0);
    chk("midrst_mask", 64'(sram_mask), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_discarded_fail", 64'(fail), 64'd0);
    chk("midrst_idle_busy", 64'(busy), 64'd0);
    f_kind = 0;
    clear_mem();
    run_test("after_reset", 0, 0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_march_bist.md
SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM address width; depth N = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM word width; multiple of 8.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port start_i, input, 1, starts a test when sampled high in IDLE.
REQ-006 SHALL have port busy_o, output, 1, high in RUN and DRAIN.
REQ-007 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-008 SHALL have port fail_o, output, 1, sticky mismatch flag, cleared on next start.
REQ-009 SHALL have port fail_addr_o, output, ADDR_W, address of first mismatch.
REQ-010 SHALL have port fail_elem_o, output, 3, march element index (0-5) of first mismatch.
REQ-011 SHALL have ports sram_cs_o (1), sram_addr_o (ADDR_W), sram_data_o (DATA_W), sram_mask_o (DATA_W/8), sram_wren_o (1), all outputs, driving the SRAM port.
REQ-012 SHALL have port sram_data_i, input, DATA_W, SRAM read data, valid the cycle after a read (cs=1, wren=0).

Function
REQ-013 SHALL run March C- with one SRAM op per RUN cycle:
- M0 up (w0)
- M1 up (r0, w1)
- M2 up (r1, w0)
- M3 down (r0, w1)
- M4 down (r1, w0)
- M5 down (r0)
Total: 10N ops.
REQ-014 SHALL use background "0" = all-zeros and "1" = all-ones.
REQ-015 For two-op elements, SHALL issue the read then the write to the same address in consecutive cycles before advancing the address.
REQ-016 "up" SHALL count 0 to N-1; "down" SHALL count N-1 to 0; no wrap beyond either end; next element starts the cycle after the last op.
REQ-017 SHALL drive sram_cs_o=1 every RUN cycle and 0 in all other states; sram_mask_o SHALL be all-ones in RUN.
REQ-018 SHALL register expected data, address and element index with each read, and compare against sram_data_i in the following cycle.
REQ-019 On the first mismatch since start, SHALL set fail_o and capture fail_addr_o/fail_elem_o. Later mismatches SHALL NOT update them. The test SHALL continue to completion.
REQ-020 FSM states and transitions:
- IDLE -> RUN on start_i=1.
- RUN -> DRAIN after the last op.
- DRAIN (final compare, cs=0) -> DONE.
- DONE (done_o=1) -> IDLE.
REQ-021 With start sampled at edge 0, done_o SHALL be high exactly in cycle 10N+2.
REQ-022 start_i SHALL be ignored outside IDLE; start_i held high in IDLE SHALL restart the test after DONE.
REQ-023 Entering RUN SHALL clear fail_o, fail_addr_o and fail_elem_o.

Reset
REQ-024 rst_n_i low at an edge SHALL force IDLE, including mid-run, and all outputs to 0, with sram_cs_o=0 from that edge.
REQ-025 Reset SHALL discard any pending compare without raising fail_o.

Configuration
REQ-026 Macro SRAM_BIST_CHECKERBOARD_EN, when defined, SHALL add a second full March C- pass after the first. In that pass "0" = 0x5555_5555 pattern and "1" = its inverse (replicated to DATA_W). Total ops = 20N; done_o is in cycle 20N+2. fail_elem_o SHALL become 4 bits with values 8-13 for the second pass.
REQ-027 When SRAM_BIST_CHECKERBOARD_EN is undefined, SHALL run the single solid-background pass only, with the 3-bit fail_elem_o.

Verification
REQ-028 Fault-free 1024x32 SRAM model, pulse start -> done_o high in cycle 10242, fail_o=0, busy_o high cycles 1-10241.
REQ-029 Model with bit 0 stuck-at-1 at address 0x155 -> fail_o=1, fail_addr_o=0x155, fail_elem_o=1; done_o still in cycle 10242.
REQ-030 Model where a write to 0x3FF flips bit 7 of 0x3FE (down-direction coupling) -> fail_o=1, fail_addr_o=0x3FE, fail_elem_o=3.
REQ-031 Extra start_i pulses at cycles 5 and 5000 of a run -> ignored; single done_o at 10242.
REQ-032 rst_n_i low at cycle 3000 with a pending mismatch -> next cycle all outputs 0, sram_cs_o=0, fail_o=0; a new start completes normally.
REQ-033 SRAM_BIST_CHECKERBOARD_EN defined, fault-free -> done_o in cycle 20482; bit 0 stuck-at-0 at address 0x0 -> fail_elem_o=2 (first-pass detection).
